// File: rtl/aer_event_packetizer.sv
// AER event packetizer: timestamps arbiter grants, packs {pol, x, y, ts} words into a FIFO, streams them out over valid/ready.
// Optional build macro TS_WRAP_MARKER_EN inserts a marker word on every timestamp wrap.
module aer_event_packetizer #(
    parameter int X_W   = 2,
    parameter int Y_W   = 2,
    parameter int TS_W  = 12,
    parameter int DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          enable_i,
    input  logic                          active_i,
    input  logic [X_W-1:0]                x_add_i,
    input  logic [Y_W-1:0]                y_add_i,
    input  logic [1:0]                    pol_i,
    input  logic                          grp_release_i,
    output logic [2+X_W+Y_W+TS_W-1:0]     evt_data_o,
    output logic                          evt_valid_o,
    input  logic                          evt_ready_i,
    output logic                          stall_o,
    output logic                          ovf_o,
    output logic [7:0]                    drop_cnt_o,
    output logic                          idle_o
);
    localparam int EVT_W = 2 + X_W + Y_W + TS_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state;
    logic [TS_W-1:0]        ts;
    logic                   act_prev;
    logic [X_W+Y_W-1:0]     last_addr;
    logic [EVT_W-1:0]       mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          count;

    logic [X_W+Y_W-1:0]     addr;
    logic                   pol_ok;
    logic                   capture;
    logic [EVT_W-1:0]       cap_word;
    logic                   pop;
    logic                   full;
    logic                   wr_req;
    logic [EVT_W-1:0]       wr_word;
    logic                   wr_ok;
    logic                   drop;
    logic [CW-1:0]          count_nxt;
    logic                   pend_busy;
    logic                   pend_next;
    logic                   unused_ok;

    // The arbiter group-release pulse carries no meaning for this block.
    assign unused_ok = grp_release_i;

    assign addr     = {x_add_i, y_add_i};
    assign pol_ok   = (pol_i == 2'b01) || (pol_i == 2'b10);
    assign capture  = (state == RUN) && active_i && pol_ok && (!act_prev || (addr != last_addr));
    assign cap_word = {pol_i, x_add_i, y_add_i, ts};

    assign evt_valid_o = (count != '0);
    assign evt_data_o  = evt_valid_o ? mem[rd_ptr] : '0;
    assign pop         = evt_valid_o && evt_ready_i;
    assign full        = (count == CW'(DEPTH));

`ifdef TS_WRAP_MARKER_EN
    logic                   ts_wrap;
    logic                   pend_vld;
    logic [EVT_W-1:0]       pend_word;
    logic [TS_W-1:0]        wrap_cnt;
    logic [TS_W-1:0]        wrap_cnt_nxt;
    logic                   pend_set;

    assign ts_wrap      = (state != IDLE) && (ts == '1);
    assign wrap_cnt_nxt = wrap_cnt + 1'b1;
    assign pend_busy    = pend_vld;
    assign pend_next    = pend_set;

    // Marker beats a pending capture, which beats a fresh capture; a displaced capture waits one cycle.
    always_comb begin
        wr_req   = capture;
        wr_word  = cap_word;
        pend_set = 1'b0;
        if (ts_wrap) begin
            wr_req   = 1'b1;
            wr_word  = {2'b11, {(X_W+Y_W){1'b0}}, wrap_cnt_nxt};
            pend_set = capture;
        end else if (pend_vld) begin
            wr_req   = 1'b1;
            wr_word  = pend_word;
            pend_set = capture;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pend_vld <= 1'b0;
            wrap_cnt <= '0;
        end else begin
            pend_vld <= pend_set;
            if (ts_wrap) begin
                wrap_cnt <= wrap_cnt_nxt;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (pend_set) begin
            pend_word <= cap_word;
        end
    end
`else
    assign pend_busy = 1'b0;
    assign pend_next = 1'b0;

    always_comb begin
        wr_req  = capture;
        wr_word = cap_word;
    end
`endif

    // A write into a full FIFO only lands when the head leaves in the same cycle.
    assign wr_ok     = wr_req && (!full || pop);
    assign drop      = wr_req && full && !pop;
    assign count_nxt = count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, pop};

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state      <= IDLE;
            idle_o     <= 1'b1;
            ts         <= '0;
            act_prev   <= 1'b0;
            last_addr  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            stall_o    <= 1'b0;
            ovf_o      <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            act_prev <= active_i;
            if (capture) begin
                last_addr <= addr;
            end
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_nxt;
            stall_o <= (count_nxt >= CW'(DEPTH - 1)) || pend_next;
            if (drop) begin
                ovf_o <= 1'b1;
                if (drop_cnt_o != 8'hFF) begin
                    drop_cnt_o <= drop_cnt_o + 8'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (enable_i) begin
                        state  <= RUN;
                        idle_o <= 1'b0;
                        ts     <= '0;
                    end
                end
                RUN: begin
                    ts <= ts + 1'b1;
                    if (!enable_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    ts <= ts + 1'b1;
                    if (enable_i) begin
                        state <= RUN;
                    end else if ((count == '0) && !wr_req && !pend_busy) begin
                        state  <= IDLE;
                        idle_o <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    idle_o <= 1'b1;
                end
            endcase
        end
    end

    // Storage array carries data only and needs no reset; emptiness is tracked by count.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_word;
        end
    end

endmodule

// File: doc/aer_event_packetizer.md
Name: aer_event_packetizer

Overview:
- Downstream neighbour of the pixel-level arbiter.
- Takes each granted pixel address (x, y) plus its 2-bit polarity code and stamps it with a free-running timestamp.
- Packs the result into an AER event word and buffers it in a FIFO.
- Delivers words over a valid/ready interface to the readout link, and drives a stall back to the arbiter when the buffer is close to full.

Parameters:
- X_W, 2, width of row address.
- Y_W, 2, width of column address.
- TS_W, 12, timestamp counter width.
- DEPTH, 8, FIFO depth in words; power of two, minimum 4.
- EVT_W, 2+X_W+Y_W+TS_W, event word width (derived localparam, not overridable).

Ports:
- clk_i  in  1  single clock.
- reset_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  block enable; the same enable given to the arbiter.
- active_i  in  1  arbiter grant-active flag.
- x_add_i  in  X_W  granted row address.
- y_add_i  in  Y_W  granted column address.
- pol_i  in  2  request code of the granted pixel: 01 = ON, 10 = OFF, others invalid.
- grp_release_i  in  1  arbiter group-release pulse.
- evt_data_o  out  EVT_W  event word {pol, x, y, ts}, MSB first.
- evt_valid_o  out  1  output word valid.
- evt_ready_i  in  1  downstream ready.
- stall_o  out  1  almost-full; the arbiter enable must be gated with it.
- ovf_o  out  1  sticky overflow flag.
- drop_cnt_o  out  8  saturating count of dropped events.
- idle_o  out  1  high in IDLE state.

Behaviour:
- Reset (reset_i=0, async):
  - FIFO is emptied; timestamp = 0; state = IDLE.
  - evt_valid_o=0, evt_data_o=0, stall_o=0, ovf_o=0, drop_cnt_o=0, idle_o=1.
- FSM states and transitions:
  - IDLE -> RUN when enable_i=1. On this transition the timestamp is cleared to 0.
  - RUN -> DRAIN when enable_i=0.
  - DRAIN -> IDLE when the FIFO is empty and there is no pending write.
  - DRAIN -> RUN if enable_i returns to 1. The timestamp is not cleared on this path.
- Timestamp:
  - Increments every cycle in RUN and DRAIN; held in IDLE.
  - Wraps from 2^TS_W-1 to 0.
- Capture (RUN only):
  - An event is captured in a cycle where active_i=1, pol_i is 01 or 10, and one of these holds:
    - active_i was 0 in the previous cycle, or
    - {x_add_i, y_add_i} differs from the last captured address.
  - This suppresses duplicates while the arbiter holds a grant.
  - Word = {pol_i, x_add_i, y_add_i, ts}, where ts is the current counter value.
  - pol_i of 00 or 11 is ignored: no write, no drop count.
  - No capture occurs in IDLE or DRAIN.
- FIFO write latency: a captured word is visible at evt_data_o no earlier than the next cycle, and evt_valid_o rises at the earliest 1 cycle after capture when the FIFO was empty.
- Output handshake:
  - evt_data_o is the FIFO head.
  - A pop occurs when evt_valid_o & evt_ready_i.
  - While evt_valid_o=1 and evt_ready_i=0, data and valid are held stable.
- Full FIFO:
  - A write while full with no pop in the same cycle is dropped: ovf_o is set (sticky until reset), and drop_cnt_o increments, saturating at 255.
  - A write while full with a pop in the same cycle succeeds; the count is unchanged.
- Empty FIFO: a simultaneous write and pop are not possible, since valid=0 at the start of the cycle; the write simply lands.
- stall_o: registered; high when count >= DEPTH-1, low otherwise.
- grp_release_i: no action in the base configuration.
- Reset mid-operation: all contents are discarded immediately; no partial word is ever presented.

Optional Feature:
- Macro: TS_WRAP_MARKER_EN.
- When defined:
  - On a timestamp wrap in RUN or DRAIN, a marker word {2'b11, zeros(X_W+Y_W), TS_W'(wrap count LSBs)} is written.
  - The marker has priority over a capture in the same cycle. The capture is held in a 1-entry pending register and written in the next cycle.
  - stall_o remains asserted while the pending register is occupied.
  - A marker or pending write that meets a full FIFO is dropped with the normal overflow accounting.
- When undefined:
  - No markers, no pending register; wrap is silent.

Test Plan:
- Basic event: reset_i=0->1, enable_i=1; at ts=5 drive active_i=1 for one cycle with x=2, y=1, pol=01 -> one word 18'b01_10_01_000000000101, evt_valid_o=1 one cycle later, pops with ready=1.
- Duplicate suppression: active_i held 4 cycles at x=3, y=3, then address changes to x=0, y=2 -> exactly 2 words.
- Backpressure and overflow (DEPTH=8): evt_ready_i=0, 10 distinct events:
  - stall_o rises when count reaches 7.
  - 8 words stored, drop_cnt_o=2, ovf_o=1.
  - Then ready=1 -> the 8 words drain in order.
- Full with simultaneous pop: FIFO full, ready=1 and a capture in the same cycle -> capture accepted, count stays 8, drop_cnt_o unchanged.
- Drain and reset: 3 words buffered, enable_i=0 -> DRAIN, 3 pops, idle_o=1; reset_i pulsed low with 2 words buffered -> evt_valid_o=0 immediately.
- TS_WRAP_MARKER_EN (TS_W=4): event coincident with ts wrap 15->0 -> marker word (pol=11) first, event next cycle with its captured ts=15.
